// File: rtl/prbs_checker_if.sv
// Serial PRBS sink interface: bit stream in, lock/error status out.
// PRBS_CHK_BITCNT_EN adds the 32-bit locked-bit counter output.
interface prbs_checker_if #(
    parameter int CNT_W = 16
);
    logic             data_i;
    logic             valid_i;
    logic             clear_i;
    logic             locked_o;
    logic             err_o;
    logic [CNT_W-1:0] err_count_o;
`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0]      bit_count_o;

    modport master (output data_i, valid_i, clear_i,
                    input  locked_o, err_o, err_count_o, bit_count_o);
    modport slave  (input  data_i, valid_i, clear_i,
                    output locked_o, err_o, err_count_o, bit_count_o);
`else
    modport master (output data_i, valid_i, clear_i,
                    input  locked_o, err_o, err_count_o);
    modport slave  (input  data_i, valid_i, clear_i,
                    output locked_o, err_o, err_count_o);
`endif
endinterface

// File: rtl/prbs_checker.sv
// PRBS checker: self-synchronises an LFSR reference to a serial stream, then counts bit errors.
// Optional PRBS_CHK_BITCNT_EN adds a modulo-2^32 count of bits checked while locked.
module prbs_checker #(
    parameter int             N           = 8,
    parameter logic [N-1:0]   TAPS        = N'(8'b00000011),
    parameter int             LOCK_CNT    = 16,
    parameter int             LOSS_WIN    = 64,
    parameter int             LOSS_THRESH = 8,
    parameter int             CNT_W       = 16
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    prbs_checker_if.slave bus
);
    localparam int FW = $clog2(N + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_WIN + 1);
    localparam int EW = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [N-1:0]     window, window_nxt;
    logic [FW-1:0]    fill_cnt, fill_nxt;
    logic [MW-1:0]    match_cnt, match_nxt;
    logic [BW-1:0]    win_bits, win_bits_nxt;
    logic [EW-1:0]    win_err, win_err_nxt, win_err_sum;
    logic [CNT_W-1:0] err_count;
    logic             err_q, err_nxt;
    logic             pred, mism;

    assign pred        = ^(window & TAPS);
    assign mism        = bus.data_i ^ pred;
    assign win_err_sum = win_err + EW'(mism);

    always_comb begin
        state_nxt    = state;
        window_nxt   = window;
        fill_nxt     = fill_cnt;
        match_nxt    = match_cnt;
        win_bits_nxt = win_bits;
        win_err_nxt  = win_err;
        err_nxt      = 1'b0;
        if (bus.valid_i) begin
            unique case (state)
                SEARCH: begin
                    window_nxt = {bus.data_i, window[N-1:1]};
                    if (fill_cnt != FW'(N))
                        fill_nxt = fill_cnt + FW'(1);
                    // all-zero is the LFSR lock-up state, never a valid reference
                    if (fill_cnt == FW'(N) && window != '0) begin
                        state_nxt = VERIFY;
                        match_nxt = '0;
                    end
                end
                VERIFY: begin
                    window_nxt = {bus.data_i, window[N-1:1]};
                    if (mism) begin
                        state_nxt = SEARCH;
                        fill_nxt  = FW'(N);
                    end else if (match_cnt == MW'(LOCK_CNT - 1)) begin
                        state_nxt    = LOCKED;
                        win_bits_nxt = '0;
                        win_err_nxt  = '0;
                    end else begin
                        match_nxt = match_cnt + MW'(1);
                    end
                end
                LOCKED: begin
                    // free-run on the prediction so a flipped bit cannot poison the reference
                    window_nxt = {pred, window[N-1:1]};
                    err_nxt    = mism;
                    if (win_bits == BW'(LOSS_WIN - 1)) begin
                        win_bits_nxt = '0;
                        win_err_nxt  = '0;
                    end else begin
                        win_bits_nxt = win_bits + BW'(1);
                        win_err_nxt  = win_err_sum;
                    end
                    if (win_err_sum >= EW'(LOSS_THRESH)) begin
                        state_nxt = SEARCH;
                        fill_nxt  = '0;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
        if (bus.clear_i) begin
            win_bits_nxt = '0;
            win_err_nxt  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= SEARCH;
            window    <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_bits  <= '0;
            win_err   <= '0;
            err_q     <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            window    <= window_nxt;
            fill_cnt  <= fill_nxt;
            match_cnt <= match_nxt;
            win_bits  <= win_bits_nxt;
            win_err   <= win_err_nxt;
            err_q     <= err_nxt;
            if (bus.clear_i)
                err_count <= '0;
            else if (err_nxt && err_count != '1)
                err_count <= err_count + CNT_W'(1);
        end
    end

    assign bus.locked_o    = (state == LOCKED);
    assign bus.err_o       = err_q;
    assign bus.err_count_o = err_count;

`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] bit_cnt;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)
            bit_cnt <= '0;
        else if (bus.clear_i)
            bit_cnt <= '0;
        else if (bus.valid_i && state == LOCKED)
            bit_cnt <= bit_cnt + 32'd1;
    end

    assign bus.bit_count_o = bit_cnt;
`endif
endmodule

// File: tb/tb_prbs_checker.sv
// Directed-vector bench for prbs_checker: lock, errors, loss/relock, gaps, clear, saturation, reset.
module tb_prbs_checker;
    logic clk = 1'b0, rst_n = 1'b0;
    logic data = 1'b0, valid = 1'b0, clear = 1'b0;
    logic [7:0] gen = 8'h01;
    int n_vec = 0, n_bad = 0;
    localparam logic [7:0] GTAPS = 8'b00000011;

    always #5 clk = ~clk;

    prbs_checker_if #(.CNT_W(16)) bus16 ();
    prbs_checker_if #(.CNT_W(4))  bus4 ();
    assign bus16.data_i  = data;
    assign bus16.valid_i = valid;
    assign bus16.clear_i = clear;
    assign bus4.data_i   = data;
    assign bus4.valid_i  = valid;
    assign bus4.clear_i  = clear;

    prbs_checker #(.CNT_W(16)) dut  (.clk_i(clk), .reset_ni(rst_n), .bus(bus16.slave));
    prbs_checker #(.CNT_W(4))  dut4 (.clk_i(clk), .reset_ni(rst_n), .bus(bus4.slave));

    typedef struct {
        logic v, f, c, l, e;
        int   cnt;
        int   rep;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic d, input logic c);
        valid = v; data = d; clear = c;
        @(posedge clk); #1;
        valid = 1'b0; clear = 1'b0;
    endtask

    // one cycle of the reference generator stream, optionally with the bit flipped
    task automatic step(input logic v, input logic f, input logic c);
        drive(v, v ? (gen[0] ^ f) : 1'($urandom_range(0, 1)), c);
        if (v) gen = {^(gen & GTAPS), gen[7:1]};
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        @(posedge clk); #1;
        rst_n = 1'b1;
        gen = 8'h01;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 24};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 10};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 30};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 5};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 5};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 10};

        #12;
        chk("reset_locked", 32'(bus16.locked_o), 0);
        chk("reset_err", 32'(bus16.err_o), 0);
        chk("reset_count", 32'(bus16.err_count_o), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        gen = 8'h01;

        // clean lock at 8+16+1, single error, gap, clear colliding with an error
        for (int r = 0; r < 9; r++) begin
            for (int k = 0; k < tbl[r].rep; k++) begin
                step(tbl[r].v, tbl[r].f, tbl[r].c);
                chk($sformatf("tbl%0d_locked", r), 32'(bus16.locked_o), 32'(tbl[r].l));
                chk($sformatf("tbl%0d_err", r), 32'(bus16.err_o), 32'(tbl[r].e));
                chk($sformatf("tbl%0d_count", r), 32'(bus16.err_count_o), 32'(tbl[r].cnt));
            end
        end

        // loss of lock: 8 errors inside 32 bits, then relock on the clean stream
        step(1'b1, 1'b0, 1'b1);
        for (int e = 1; e <= 8; e++) begin
            repeat (3) step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            chk("loss_err", 32'(bus16.err_o), 1);
            chk("loss_count", 32'(bus16.err_count_o), 32'(e));
            chk("loss_locked", 32'(bus16.locked_o), (e < 8) ? 32'd1 : 32'd0);
        end
        for (int k = 1; k <= 25; k++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("relock_locked", 32'(bus16.locked_o), (k >= 25) ? 32'd1 : 32'd0);
            chk("relock_err", 32'(bus16.err_o), 0);
        end
        chk("relock_count", 32'(bus16.err_count_o), 8);

        // all-zero stream must never leave SEARCH
        do_reset();
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, 1'b0, 1'b0);
            chk("zeros_locked", 32'(bus16.locked_o), 0);
            chk("zeros_err", 32'(bus16.err_o), 0);
        end

        // random valid gaps: lock still lands on exactly the 25th valid bit
        do_reset();
        begin
            int vb = 0, it = 0;
            while (vb < 25 && it < 1000) begin
                it++;
                if ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, 1'b0);
                else begin
                    step(1'b1, 1'b0, 1'b0);
                    vb++;
                end
                chk("gap_locked", 32'(bus16.locked_o), (vb >= 25) ? 32'd1 : 32'd0);
            end
            chk("gap_budget", 32'(vb), 25);
        end

        // saturation: 20 errors spaced 16 bits apart, never reaching loss threshold
        step(1'b1, 1'b0, 1'b1);
        for (int e = 1; e <= 20; e++) begin
            repeat (15) step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            chk("sat_count4", 32'(bus4.err_count_o), (e > 15) ? 32'd15 : 32'(e));
        end
        chk("sat_count16", 32'(bus16.err_count_o), 20);
        chk("sat_locked", 32'(bus16.locked_o), 1);
        chk("sat_locked4", 32'(bus4.locked_o), 1);

        // reset mid-lock acts without a clock edge
        rst_n = 1'b0;
        #2;
        chk("areset_locked", 32'(bus16.locked_o), 0);
        chk("areset_count", 32'(bus16.err_count_o), 0);
        chk("areset_count4", 32'(bus4.err_count_o), 0);
        chk("areset_err", 32'(bus16.err_o), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        gen = 8'h01;

        repeat (25) step(1'b1, 1'b0, 1'b0);
        chk("bc_locked_pre", 32'(bus16.locked_o), 1);
        step(1'b0, 1'b0, 1'b1);
        repeat (1000) step(1'b1, 1'b0, 1'b0);
        chk("bc_locked", 32'(bus16.locked_o), 1);
        chk("bc_count", 32'(bus16.err_count_o), 0);
`ifdef PRBS_CHK_BITCNT_EN
        chk("bit_count", bus16.bit_count_o, 1000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
